// File: rtl/conv_matrix_engine_pkg.sv
// conv_pkg: types and elaboration-time helpers shared by the convolution engine.
//   state_t   - engine state (IDLE, LOAD, COMPUTE)
//   clog2     - ceiling log2, clog2(1) = 0
//   acc_width - exact signed width of a KxK sum of unsigned-pixel x signed-weight
//               products
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    int unsigned span;
    width = 0;
    span  = 1;
    while (span < value) begin
      span  = span << 1;
      width++;
    end
    return width;
  endfunction

  function automatic int unsigned acc_width(input int unsigned pix_w,
                                            input int unsigned kw_w,
                                            input int unsigned k);
    return pix_w + kw_w + clog2(k * k);
  endfunction

endpackage

// File: rtl/conv_matrix_engine_if.sv
// conv_matrix_engine_if: result stream with a valid/ready handshake.
//   out_valid - result available (producer)
//   out_ready - consumer accepts the result
//   out_data  - signed convolution result, DATA_W bits (producer)
//   out_last  - final result of the frame (producer)
// master = producer side (engine), slave = consumer side.
interface conv_matrix_engine_if #(
  parameter int unsigned DATA_W = 9
);

  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/conv_matrix_engine_mac.sv
// conv_window_mac: purely combinational KxK multiply-accumulate.
//   win    - K*K unsigned pixels, pixel (i,j) at [(i*K+j)*PIX_W +: PIX_W]
//   kernel - K*K signed weights, weight (i,j) at [(i*K+j)*KW_W +: KW_W]
//   sum    - signed sum of pixel*weight, ACC_W bits (exact, never overflows)
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int unsigned K     = 3,
  parameter int unsigned PIX_W = 1,
  parameter int unsigned KW_W  = 4,
  parameter int unsigned ACC_W = 9
) (
  input  logic [K*K*PIX_W-1:0]    win,
  input  logic [K*K*KW_W-1:0]     kernel,
  output logic signed [ACC_W-1:0] sum
);

  logic [PIX_W-1:0]        pix;
  logic signed [KW_W-1:0]  weight;
  logic signed [ACC_W-1:0] pix_ext;
  logic signed [ACC_W-1:0] weight_ext;

  // Pixels are zero-extended and weights sign-extended to ACC_W before the
  // multiply, so every product and the running sum stay exact at ACC_W bits.
  always_comb begin
    sum        = '0;
    pix        = '0;
    weight     = '0;
    pix_ext    = '0;
    weight_ext = '0;
    for (int unsigned n = 0; n < K * K; n++) begin
      pix        = PIX_W'(win >> (n * PIX_W));
      weight     = KW_W'(kernel >> (n * KW_W));
      pix_ext    = ACC_W'(pix);
      weight_ext = ACC_W'(weight);
      sum        = sum + pix_ext * weight_ext;
    end
  end

endmodule

// File: rtl/conv_matrix_engine.sv
// conv_matrix_engine: loads a square unsigned image one row per strobe edge,
// then slides a KxK signed kernel over it (valid padding, stride 1) and
// streams the results out in row-major order.
//   clk, rst     - clock, synchronous active-high reset
//   row_strobe   - switch level; its rising edge commits row_data as next row
//   row_data     - one image row, pixel c at [c*PIX_W +: PIX_W]
//   kernel       - weight (r,c) at [(r*K+c)*KW_W +: KW_W]; hold stable in COMPUTE
//   res_bus      - result stream (out_valid/out_ready/out_data/out_last)
//   busy         - high while computing
//   rows_loaded  - rows committed in the current frame
module conv_matrix_engine
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = 6,
  parameter int unsigned K     = 3,
  parameter int unsigned PIX_W = 1,
  parameter int unsigned KW_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         row_strobe,
  input  logic [IMG_W*PIX_W-1:0]       row_data,
  input  logic [K*K*KW_W-1:0]          kernel,
  conv_matrix_engine_if.master         res_bus,
  output logic                         busy,
  output logic [clog2(IMG_W+1)-1:0]    rows_loaded
);

  localparam int unsigned ACC_W    = acc_width(PIX_W, KW_W, K);
  localparam int unsigned CNT_W    = clog2(IMG_W + 1);
  localparam int unsigned ROW_BITS = IMG_W * PIX_W;
  localparam int unsigned IMG_BITS = IMG_W * ROW_BITS;
  localparam int unsigned WIN_BITS = K * K * PIX_W;

  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(IMG_W - K);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_W - 1);

  state_t                  state;
  logic                    strobe_q;
  logic                    strobe_edge;
  logic                    load_phase;
  logic                    row_we;
  logic [IMG_BITS-1:0]     img;
  logic [IMG_BITS-1:0]     row_mask;
  logic [IMG_BITS-1:0]     row_ins;
  logic [CNT_W-1:0]        wr;
  logic [CNT_W-1:0]        wc;
  logic                    at_last;
  logic                    gen_done;
  logic                    out_free;
  logic [ROW_BITS-1:0]     row_sel;
  logic [WIN_BITS-1:0]     win;
  logic signed [ACC_W-1:0] mac_sum;

  assign strobe_edge = row_strobe & ~strobe_q;
  assign load_phase  = (state == IDLE) || (state == LOAD);
  assign row_we      = load_phase && strobe_edge;
  assign at_last     = (wr == LAST_POS) && (wc == LAST_POS);
  assign out_free    = ~res_bus.out_valid | res_bus.out_ready;

  // The image is kept as one flat vector, row r at [r*ROW_BITS +: ROW_BITS];
  // writes and window reads use shifts so no index ever exceeds its range.
  // rows_loaded is 0 in IDLE, so the same write path serves row 0.
  assign row_mask = IMG_BITS'({ROW_BITS{1'b1}}) << (32'(rows_loaded) * ROW_BITS);
  assign row_ins  = IMG_BITS'(row_data) << (32'(rows_loaded) * ROW_BITS);

  // Image storage has no reset; a discarded frame is simply overwritten.
  always_ff @(posedge clk) begin
    if (row_we) begin
      img <= (img & ~row_mask) | row_ins;
    end
  end

  // Gather the KxK window whose top-left pixel is (wr, wc).
  always_comb begin
    win     = '0;
    row_sel = '0;
    for (int unsigned i = 0; i < K; i++) begin
      row_sel = ROW_BITS'(img >> ((32'(wr) + i) * ROW_BITS));
      for (int unsigned j = 0; j < K; j++) begin
        win = win | (WIN_BITS'(PIX_W'(row_sel >> ((32'(wc) + j) * PIX_W)))
                     << ((i * K + j) * PIX_W));
      end
    end
  end

  conv_window_mac #(
    .K     (K),
    .PIX_W (PIX_W),
    .KW_W  (KW_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .win    (win),
    .kernel (kernel),
    .sum    (mac_sum)
  );

  // gen_done marks that the last window has been issued into the output
  // register; the engine then only waits for that final transfer. Strobe
  // edges are only acted on in IDLE/LOAD, so COMPUTE ignores them entirely.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      strobe_q         <= 1'b0;
      rows_loaded      <= '0;
      busy             <= 1'b0;
      wr               <= '0;
      wc               <= '0;
      gen_done         <= 1'b0;
      res_bus.out_valid <= 1'b0;
      res_bus.out_data  <= '0;
      res_bus.out_last  <= 1'b0;
    end else begin
      strobe_q <= row_strobe;
      case (state)
        IDLE, LOAD: begin
          if (strobe_edge) begin
            rows_loaded <= rows_loaded + 1'b1;
            if (rows_loaded == LAST_ROW) begin
              state    <= COMPUTE;
              busy     <= 1'b1;
              wr       <= '0;
              wc       <= '0;
              gen_done <= 1'b0;
            end else begin
              state <= LOAD;
            end
          end
        end
        COMPUTE: begin
          if (res_bus.out_valid && res_bus.out_ready && res_bus.out_last) begin
            state             <= IDLE;
            busy              <= 1'b0;
            rows_loaded       <= '0;
            res_bus.out_valid <= 1'b0;
            res_bus.out_last  <= 1'b0;
          end else if (!gen_done && out_free) begin
            res_bus.out_data  <= mac_sum;
            res_bus.out_valid <= 1'b1;
            res_bus.out_last  <= at_last;
            if (at_last) begin
              gen_done <= 1'b1;
            end else if (wc == LAST_POS) begin
              wc <= '0;
              wr <= wr + 1'b1;
            end else begin
              wc <= wc + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_matrix_engine.sv
// Self-checking bench for conv_matrix_engine at default parameters.
module tb_conv_matrix_engine;
  import conv_pkg::*;

  localparam int unsigned IMG_W = 6;
  localparam int unsigned K     = 3;
  localparam int unsigned PIX_W = 1;
  localparam int unsigned KW_W  = 4;
  localparam int unsigned ACC_W = acc_width(PIX_W, KW_W, K);

  logic        clk = 1'b0;
  logic        rst;
  logic        row_strobe;
  logic [5:0]  row_data;
  logic [35:0] kernel;
  logic        busy;
  logic [2:0]  rows_loaded;

  conv_matrix_engine_if #(.DATA_W(ACC_W)) res_bus ();

  conv_matrix_engine #(
    .IMG_W (IMG_W),
    .K     (K),
    .PIX_W (PIX_W),
    .KW_W  (KW_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row_strobe  (row_strobe),
    .row_data    (row_data),
    .kernel      (kernel),
    .res_bus     (res_bus),
    .busy        (busy),
    .rows_loaded (rows_loaded)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Stimulus image: pixel (r,c) at bit r*6+c. Weights: weight n at [n*4 +: 4].
  logic [35:0] img_bits;
  logic [35:0] kw_bits;

  logic signed [ACC_W-1:0] got[$];
  logic                    got_last[$];
  logic signed [ACC_W-1:0] ref_q[$];
  int   first_valid;
  int   hold_err;
  int   rl_err;
  logic busy0;
  logic busy_after;
  logic valid_after;
  logic [2:0] rows_after;

  function automatic int model(input int wr, input int wc);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        logic [3:0] wb;
        int wv;
        int p;
        wb = 4'(kw_bits >> ((i * 3 + j) * 4));
        wv = int'($signed(wb));
        p  = int'(1'(img_bits >> ((wr + i) * 6 + wc + j)));
        s += p * wv;
      end
    end
    return s;
  endfunction

  task automatic set_pix(input int r, input int c, input int v);
    img_bits = (img_bits & ~(36'(1) << (r * 6 + c))) | (36'(1'(v)) << (r * 6 + c));
  endtask

  task automatic load_row(input logic [5:0] d);
    @(negedge clk);
    row_data   = d;
    row_strobe = 1'b1;
    @(negedge clk);
    row_strobe = 1'b0;
  endtask

  task automatic load_frame();
    kernel = kw_bits;
    for (int r = 0; r < 6; r++) load_row(6'(img_bits >> (r * 6)));
  endtask

  // Called at the negedge straight after the final row commit (index 0).
  task automatic collect(input bit rand_ready, input bit strobe_mode, input int budget);
    bit done;
    bit prev_stall;
    logic signed [ACC_W-1:0] prev_data;
    logic prev_last;
    done = 0;
    prev_stall = 0;
    prev_data = '0;
    prev_last = 0;
    got.delete();
    got_last.delete();
    first_valid = -1;
    hold_err = 0;
    rl_err = 0;
    busy0 = 1'b0;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      res_bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (strobe_mode) row_strobe = (cyc % 2 == 0);
      #1;
      if (cyc == 0) busy0 = busy;
      if (res_bus.out_valid && first_valid < 0) first_valid = cyc;
      if (strobe_mode && busy && rows_loaded != 3'd6) rl_err++;
      if (prev_stall && (res_bus.out_valid !== 1'b1 || res_bus.out_data !== prev_data ||
                         res_bus.out_last !== prev_last)) hold_err++;
      prev_stall = res_bus.out_valid && !res_bus.out_ready;
      prev_data  = res_bus.out_data;
      prev_last  = res_bus.out_last;
      if (res_bus.out_valid && res_bus.out_ready) begin
        got.push_back(res_bus.out_data);
        got_last.push_back(res_bus.out_last);
        if (res_bus.out_last || got.size() >= 32) done = 1;
      end
      @(negedge clk);
    end
    #1;
    busy_after  = busy;
    valid_after = res_bus.out_valid;
    rows_after  = rows_loaded;
    res_bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    row_strobe = 1'b0;
    row_data = '0;
    kernel = '0;
    res_bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (rows_loaded !== 3'd0) begin failed++; $display("FAIL reset_rows got %0d exp 0", rows_loaded); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (res_bus.out_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b exp 0", res_bus.out_valid); end
    tests++; if (res_bus.out_last !== 1'b0) begin failed++; $display("FAIL reset_last got %b exp 0", res_bus.out_last); end
    tests++; if (res_bus.out_data !== '0) begin failed++; $display("FAIL reset_data got %0d exp 0", res_bus.out_data); end
  endtask

  task automatic test_all_ones();
    img_bits = '1;
    kw_bits  = 36'h111111111;
    load_frame();
    collect(1'b0, 1'b0, 60);
    tests++; if (got.size() !== 16) begin failed++; $display("FAIL ones_count got %0d exp 16", got.size()); end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      tests++; if (int'(got[i]) !== 9) begin failed++; $display("FAIL ones_data[%0d] got %0d exp 9", i, got[i]); end
      tests++; if (got_last[i] !== (i == 15)) begin failed++; $display("FAIL ones_last[%0d] got %b exp %b", i, got_last[i], i == 15); end
    end
    tests++; if (busy0 !== 1'b1) begin failed++; $display("FAIL ones_busy_start got %b exp 1", busy0); end
    tests++; if (first_valid !== 1) begin failed++; $display("FAIL ones_first_valid got %0d exp 1", first_valid); end
    tests++; if (busy_after !== 1'b0) begin failed++; $display("FAIL ones_busy_end got %b exp 0", busy_after); end
    tests++; if (valid_after !== 1'b0) begin failed++; $display("FAIL ones_valid_end got %b exp 0", valid_after); end
    tests++; if (rows_after !== 3'd0) begin failed++; $display("FAIL ones_rows_end got %0d exp 0", rows_after); end
  endtask

  task automatic test_checker_neg();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) set_pix(r, c, (r + c) % 2);
    kw_bits = 36'hFFFFFFFFF;
    load_frame();
    collect(1'b0, 1'b0, 60);
    tests++; if (got.size() !== 16) begin failed++; $display("FAIL checker_count got %0d exp 16", got.size()); end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      int exp;
      exp = (((i / 4) + (i % 4)) % 2 == 0) ? -4 : -5;
      tests++; if (int'(got[i]) !== exp) begin failed++; $display("FAIL checker_data[%0d] got %0d exp %0d", i, got[i], exp); end
    end
  endtask

  task automatic test_identity();
    img_bits = 36'hA5C3E61D9;
    kw_bits  = 36'h000010000;
    load_frame();
    collect(1'b0, 1'b0, 60);
    tests++; if (got.size() !== 16) begin failed++; $display("FAIL ident_count got %0d exp 16", got.size()); end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      int exp;
      exp = int'(1'(img_bits >> ((i / 4 + 1) * 6 + (i % 4) + 1)));
      tests++; if (int'(got[i]) !== exp) begin failed++; $display("FAIL ident_data[%0d] got %0d exp %0d", i, got[i], exp); end
    end
  endtask

  task automatic test_backpressure();
    img_bits = 36'h5B29CE473;
    kw_bits  = 36'h287A5C3E1;
    load_frame();
    collect(1'b0, 1'b0, 60);
    ref_q = got;
    tests++; if (ref_q.size() !== 16) begin failed++; $display("FAIL bp_ref_count got %0d exp 16", ref_q.size()); end
    for (int i = 0; i < ref_q.size() && i < 16; i++) begin
      tests++; if (int'(ref_q[i]) !== model(i / 4, i % 4)) begin failed++; $display("FAIL bp_ref[%0d] got %0d exp %0d", i, ref_q[i], model(i / 4, i % 4)); end
    end
    load_frame();
    collect(1'b1, 1'b0, 300);
    tests++; if (got.size() !== 16) begin failed++; $display("FAIL bp_count got %0d exp 16", got.size()); end
    tests++; if (hold_err !== 0) begin failed++; $display("FAIL bp_hold got %0d exp 0", hold_err); end
    for (int i = 0; i < got.size() && i < 16 && i < ref_q.size(); i++) begin
      tests++; if (got[i] !== ref_q[i]) begin failed++; $display("FAIL bp_data[%0d] got %0d exp %0d", i, got[i], ref_q[i]); end
      tests++; if (got_last[i] !== (i == 15)) begin failed++; $display("FAIL bp_last[%0d] got %b exp %b", i, got_last[i], i == 15); end
    end
    tests++; if (busy_after !== 1'b0) begin failed++; $display("FAIL bp_busy_end got %b exp 0", busy_after); end
  endtask

  task automatic test_strobe();
    img_bits = 36'hC3F0A96E5;
    kw_bits  = 36'h1F2E3D4C5;
    kernel   = kw_bits;
    @(negedge clk);
    row_data   = 6'(img_bits);
    row_strobe = 1'b1;
    repeat (10) @(negedge clk);
    row_strobe = 1'b0;
    @(negedge clk);
    tests++; if (rows_loaded !== 3'd1) begin failed++; $display("FAIL hold_rows got %0d exp 1", rows_loaded); end
    for (int r = 1; r < 6; r++) load_row(6'(img_bits >> (r * 6)));
    collect(1'b0, 1'b1, 60);
    tests++; if (rl_err !== 0) begin failed++; $display("FAIL compute_rows got %0d exp 0", rl_err); end
    tests++; if (got.size() !== 16) begin failed++; $display("FAIL strobe_count got %0d exp 16", got.size()); end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      tests++; if (int'(got[i]) !== model(i / 4, i % 4)) begin failed++; $display("FAIL strobe_data[%0d] got %0d exp %0d", i, got[i], model(i / 4, i % 4)); end
    end
    tests++; if (rows_after !== 3'd0) begin failed++; $display("FAIL final_edge_rows got %0d exp 0", rows_after); end
    row_strobe = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (rows_loaded !== 3'd0) begin failed++; $display("FAIL idle_rows got %0d exp 0", rows_loaded); end
  endtask

  task automatic test_mid_reset();
    repeat (3) load_row(6'h3F);
    tests++; if (rows_loaded !== 3'd3) begin failed++; $display("FAIL partial_rows got %0d exp 3", rows_loaded); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (rows_loaded !== 3'd0) begin failed++; $display("FAIL rst_rows got %0d exp 0", rows_loaded); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL rst_busy got %b exp 0", busy); end
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) set_pix(r, c, (r + c) % 2);
    kw_bits = 36'h111111111;
    load_frame();
    collect(1'b0, 1'b0, 60);
    tests++; if (got.size() !== 16) begin failed++; $display("FAIL rst_count got %0d exp 16", got.size()); end
    tests++; if (first_valid !== 1) begin failed++; $display("FAIL rst_first_valid got %0d exp 1", first_valid); end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      int exp;
      exp = (((i / 4) + (i % 4)) % 2 == 0) ? 4 : 5;
      tests++; if (int'(got[i]) !== exp) begin failed++; $display("FAIL rst_data[%0d] got %0d exp %0d", i, got[i], exp); end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_checker_neg();
    test_identity();
    test_backpressure();
    test_strobe();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_matrix_engine.md
# conv_matrix_engine

Parametrised successor to the switch-driven 6x6 matrix loader and convolution layer. It loads a square unsigned image one row per strobe edge, then slides a KxK signed kernel over it (valid padding, stride 1). Results stream out in row-major order on a valid/ready handshake. It sits between the TinyTapeout pin wrapper (switch inputs) and the output mux or serialiser.

## Interface
- `IMG_W`, 6: image width and height in pixels (square), ≥ K.
- `K`, 3: kernel width and height (square), ≥ 1.
- `PIX_W`, 1: unsigned pixel width.
- `KW_W`, 4: signed two's-complement kernel weight width.
- `ACC_W`, derived = PIX_W + KW_W + clog2(K*K): signed result width. Not overridable.
- `clk` input 1: clock. All logic is on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `row_strobe` input 1: level from the switch. The internal rising edge commits one row.
- `row_data` input IMG_W*PIX_W: one image row; pixel c occupies bits [c*PIX_W +: PIX_W].
- `kernel` input K*K*KW_W: weight (r,c) occupies bits [(r*K+c)*KW_W +: KW_W]. Must be held stable outside IDLE/LOAD.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output ACC_W: signed convolution result.
- `out_last` output 1: high with the final result of the frame.
- `busy` output 1: high in COMPUTE.
- `rows_loaded` output clog2(IMG_W+1): number of rows committed in the current frame.

## Operation
- Reset values: state IDLE, `strobe_q`=0, `rows_loaded`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0. Image storage is not reset.
- Edge detect: `edge = row_strobe & ~strobe_q`. `strobe_q` is registered every cycle. A strobe held high commits exactly one row.
- IDLE: `edge` writes `row_data` to row 0, sets `rows_loaded`=1, and moves to LOAD.
- LOAD: `edge` writes row[`rows_loaded`] and increments the count. The edge that commits row IMG_W-1 moves to COMPUTE.
- COMPUTE: window position (wr, wc) starts at (0,0).
  - The datapath computes sum over i,j of `$signed({1'b0,pix[wr+i][wc+j]}) * $signed(w[i][j])`, sign-extended to ACC_W. No saturation is needed because ACC_W is exact.
  - The result is registered into `out_data` when the output register is empty or is being accepted in the same cycle.
  - Traversal advances wc first, then wr. Last position is (IMG_W-K, IMG_W-K); `out_last` is set with it.
- Handshake: a transfer occurs when `out_valid & out_ready`. `out_data` and `out_last` are stable while `out_valid & ~out_ready`. Results are never dropped or duplicated.
- The transfer with `out_last`=1 moves to IDLE, clears `rows_loaded`, and drops `out_valid` next cycle.
- Strobe edges during COMPUTE are ignored: no write and no count change. This includes an edge in the same cycle as the final transfer. `strobe_q` still tracks the input.
- `rst` in any state returns all registers to reset values on the next edge. A partially loaded frame is discarded.
- Total results per frame: (IMG_W-K+1)^2, which is 16 at defaults.

## Timing
- Row commit: edge sampled at cycle t, row written and `rows_loaded` updated at the clock edge ending cycle t.
- Final row edge at cycle t: state is COMPUTE and `busy`=1 in cycle t+1. The first `out_valid`=1 appears in cycle t+2.
- With `out_ready` held at 1, results come one per cycle. The last transfer is in cycle t+1+(IMG_W-K+1)^2, and `busy`=0 the cycle after.
- Backpressure stalls window advance with zero bubbles on release.
- The MAC is single-cycle combinational: K*K multipliers. Fine at the defaults.

## Structure
- Shared package `conv_pkg`:
  - state enum (IDLE, LOAD, COMPUTE);
  - a `clog2` helper function;
  - ACC_W derivation function.
- One sub-module, `conv_window_mac`: purely combinational KxK multiply-accumulate, taking window pixels and kernel and producing an ACC_W result.
- Top holds the image store, edge detector, FSM, window counters and output register.

## Test plan
- Defaults, all-ones image, all weights +1, `out_ready`=1 → 16 results, each 9. `out_last` only on the 16th. First `out_valid` 2 cycles after the 6th row edge.
- All weights -1 (4'hF), checkerboard image with row 0 = 101010 → every result -4 or -5, alternating per the window parity.
- Identity kernel (centre weight 1, rest 0), row r = pixel pattern r → result (wr,wc) equals pix[wr+1][wc+1] for all 16 positions.
- `out_ready` toggling pseudo-randomly → `out_data` holds during stalls, and the sequence is identical to the no-stall run.
- Strobe held high for 10 cycles → `rows_loaded` increments by exactly 1. Strobe edges during COMPUTE → `rows_loaded` unchanged, and the output sequence is unaffected.
- `rst` pulse after 3 rows, then 6 fresh rows → `rows_loaded` reads 0 after reset. Results reflect only the new frame.
